hamming_rx_sched: RTL and testbench

- Receive-side scheduler that shares one Hamming (7,4) syndrome/correct datapath between NUM_CH requesting channels.
- Each channel offers a 7-bit codeword with a valid/ready handshake.
- The block grants one channel at a time, round-robin. It captures the word, computes the syndrome, corrects any single-bit error and presents the 4-bit data on one output port with valid/ready.
- It sits between the per-link deserialisers and the packet assembler, and also keeps a saturating corrected-error count.

---
 rtl/hamming_pkg.sv | 32 +++
 rtl/hamming_rx_sched_syn_calc.sv | 24 ++
 rtl/hamming_rx_sched.sv | 140 ++++++++++++++
 tb/tb_hamming_rx_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared constants, FSM state type and syndrome decode for the Hamming (7,4) receive scheduler.
package hamming_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  // Bit position 7 never exists in a 7-bit word, so it doubles as "no flip".
  localparam logic [2:0] POS_NONE = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    OUT
  } state_e;

  function automatic logic [2:0] syn_to_pos(input logic [SYN_W-1:0] syn);
    logic [2:0] pos;
    case (syn)
      3'd6:    pos = 3'd0;
      3'd5:    pos = 3'd1;
      3'd3:    pos = 3'd2;
      3'd7:    pos = 3'd3;
      3'd1:    pos = 3'd4;
      3'd2:    pos = 3'd5;
      3'd4:    pos = 3'd6;
      default: pos = POS_NONE;
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/hamming_rx_sched_syn_calc.sv
// Combinational syndrome and single-error correction of one (7,4) codeword; data nibble only.
module hamming_syn_calc
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SYN_W-1:0]  syn,
  output logic [DATA_W-1:0] data
);

  logic [2:0]        pos;
  logic [DATA_W-1:0] data_flip;

  always_comb begin
    syn[2] = code[0] ^ code[1] ^ code[3] ^ code[6];
    syn[1] = code[0] ^ code[2] ^ code[3] ^ code[5];
    syn[0] = code[1] ^ code[2] ^ code[3] ^ code[4];
    pos    = syn_to_pos(syn);
    // A flipped parity bit (positions 4..6) leaves the data nibble untouched.
    data_flip = '0;
    if (pos[2] == 1'b0) data_flip[pos[1:0]] = 1'b1;
    data = code[DATA_W-1:0] ^ data_flip;
  end

endmodule

// File: rtl/hamming_rx_sched.sv
// Round-robin scheduler sharing one Hamming (7,4) correct datapath across NUM_CH channels.
// States: IDLE grant+capture | CALC syndrome/correct/count | OUT hold result until out_ready.
module hamming_rx_sched
  import hamming_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [CODE_W*NUM_CH-1:0] ch_code,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic [SYN_W-1:0]         out_syn,
  output logic                     out_corr,
  input  logic                     clr_cnt,
  output logic [CNT_W-1:0]         corr_cnt
);

  localparam int PW = CH_W + 1;

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [CH_W-1:0]     out_ch_q, out_ch_d;
  logic [SYN_W-1:0]    out_syn_q, out_syn_d;
  logic                out_corr_q, out_corr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                found;
  logic [CH_W-1:0]     win;
  logic [PW-1:0]       cand;
  logic [PW-1:0]       ptr_inc;
  logic [CH_W-1:0]     ptr_nxt;
  logic [SYN_W-1:0]    calc_syn;
  logic [DATA_W-1:0]   calc_data;

  hamming_syn_calc u_syn_calc (
    .code (code_q),
    .syn  (calc_syn),
    .data (calc_data)
  );

  // Wrap-around search starting at the priority pointer; first valid wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, ptr_q} + PW'(k);
      if (cand >= PW'(NUM_CH)) cand = cand - PW'(NUM_CH);
      if (!found && ch_valid[cand[CH_W-1:0]]) begin
        found = 1'b1;
        win   = cand[CH_W-1:0];
      end
    end
    ptr_inc = {1'b0, win} + PW'(1);
    if (ptr_inc >= PW'(NUM_CH)) ptr_nxt = '0;
    else                        ptr_nxt = ptr_inc[CH_W-1:0];
  end

  always_comb begin
    ch_ready = '0;
    if (state_q == IDLE && found) ch_ready[win] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    ch_d       = ch_q;
    ptr_d      = ptr_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    out_syn_d  = out_syn_q;
    out_corr_d = out_corr_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          code_d  = ch_code[int'(win)*CODE_W +: CODE_W];
          ch_d    = win;
          ptr_d   = ptr_nxt;
          state_d = CALC;
        end
      end
      CALC: begin
        out_data_d = calc_data;
        out_ch_d   = ch_q;
        out_syn_d  = calc_syn;
        out_corr_d = |calc_syn;
        if ((|calc_syn) && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr_cnt) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      code_q     <= '0;
      ch_q       <= '0;
      ptr_q      <= '0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      out_syn_q  <= '0;
      out_corr_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      ch_q       <= ch_d;
      ptr_q      <= ptr_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      out_syn_q  <= out_syn_d;
      out_corr_q <= out_corr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = (state_q == OUT);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_syn   = out_syn_q;
  assign out_corr  = out_corr_q;
  assign corr_cnt  = cnt_q;

endmodule

// File: tb/tb_hamming_rx_sched.sv
// Directed bench for hamming_rx_sched: vector table plus handshake, fairness, counter and reset sequences.
module tb_hamming_rx_sched;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 4;

  logic                clk;
  logic                rst_n;
  logic [NUM_CH-1:0]   ch_valid;
  logic [7*NUM_CH-1:0] ch_code;
  logic [NUM_CH-1:0]   ch_ready;
  logic                out_valid;
  logic                out_ready;
  logic [3:0]          out_data;
  logic [CH_W-1:0]     out_ch;
  logic [2:0]          out_syn;
  logic                out_corr;
  logic                clr_cnt;
  logic [CNT_W-1:0]    corr_cnt;

  hamming_rx_sched #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_valid  (ch_valid),
    .ch_code   (ch_code),
    .ch_ready  (ch_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_syn   (out_syn),
    .out_corr  (out_corr),
    .clr_cnt   (clr_cnt),
    .corr_cnt  (corr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic [6:0] code;
    logic [3:0] data;
    logic [2:0] syn;
    logic       corr;
  } vec_t;

  vec_t vecs[13];
  int   n_vec;
  int   n_err;
  int   exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic offer(input int ch, input logic [6:0] code);
    ch_valid           = '0;
    ch_valid[ch]       = 1'b1;
    ch_code[ch*7 +: 7] = code;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 0;
  endtask

  // One word through the pipe with out_ready held high: grant, CALC, OUT, back to IDLE.
  task automatic run_word(input int ch, input logic [6:0] code, input logic [3:0] data,
                          input logic [2:0] syn, input logic corr);
    @(negedge clk);
    offer(ch, code);
    #1 chk("grant", 32'(ch_ready), 32'(4'b0001 << ch));
    @(negedge clk);
    ch_valid = '0;
    #1 chk("calc_ready", 32'(ch_ready), 32'd0);
    chk("calc_valid", 32'(out_valid), 32'd0);
    if (corr && exp_cnt != 15) exp_cnt++;
    @(negedge clk);
    #1 chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_data", 32'(out_data), 32'(data));
    chk("out_ch", 32'(out_ch), 32'(ch));
    chk("out_syn", 32'(out_syn), 32'(syn));
    chk("out_corr", 32'(out_corr), 32'(corr));
    chk("corr_cnt", 32'(corr_cnt), 32'(exp_cnt));
    @(negedge clk);
    #1 chk("out_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 7'h4B, 4'hB, 3'd0, 1'b0};
    vecs[1]  = '{1, 7'h4F, 4'hB, 3'd3, 1'b1};
    vecs[2]  = '{2, 7'h4A, 4'hB, 3'd6, 1'b1};
    vecs[3]  = '{3, 7'h49, 4'hB, 3'd5, 1'b1};
    vecs[4]  = '{0, 7'h4F, 4'hB, 3'd3, 1'b1};
    vecs[5]  = '{1, 7'h43, 4'hB, 3'd7, 1'b1};
    vecs[6]  = '{2, 7'h5B, 4'hB, 3'd1, 1'b1};
    vecs[7]  = '{3, 7'h6B, 4'hB, 3'd2, 1'b1};
    vecs[8]  = '{0, 7'h0B, 4'hB, 3'd4, 1'b1};
    vecs[9]  = '{2, 7'h55, 4'h5, 3'd0, 1'b0};
    vecs[10] = '{3, 7'h00, 4'h0, 3'd0, 1'b0};
    vecs[11] = '{0, 7'h7F, 4'hF, 3'd0, 1'b0};
    vecs[12] = '{1, 7'h48, 4'hC, 3'd3, 1'b1};

    n_vec     = 0;
    n_err     = 0;
    exp_cnt   = 0;
    rst_n     = 1'b0;
    ch_valid  = '0;
    ch_code   = '0;
    out_ready = 1'b1;
    clr_cnt   = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("rst_ready", 32'(ch_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_cnt", 32'(corr_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++)
      run_word(vecs[i].ch, vecs[i].code, vecs[i].data, vecs[i].syn, vecs[i].corr);

    // Fairness: all channels request continuously.
    do_reset();
    for (int c = 0; c < NUM_CH; c++) ch_code[c*7 +: 7] = 7'h4B;
    ch_valid = '1;
    for (int k = 0; k < 24; k++) begin
      #1 chk("rr_grant", 32'(ch_ready), (k % 3 == 0) ? 32'(4'b0001 << ((k / 3) % 4)) : 32'd0);
      chk("rr_valid", 32'(out_valid), (k % 3 == 2) ? 32'd1 : 32'd0);
      if (k % 3 == 2) chk("rr_out_ch", 32'(out_ch), 32'((k / 3) % 4));
      @(negedge clk);
    end
    ch_valid = '0;

    // Backpressure: ten stalled cycles in OUT while ch1 waits.
    @(negedge clk);
    out_ready = 1'b0;
    offer(2, 7'h6B);
    #1 chk("bp_grant", 32'(ch_ready), 32'b0100);
    @(negedge clk);
    offer(1, 7'h4B);
    #1 chk("bp_calc_ready", 32'(ch_ready), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1 chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'hB);
      chk("bp_ch", 32'(out_ch), 32'd2);
      chk("bp_syn", 32'(out_syn), 32'd2);
      chk("bp_ready", 32'(ch_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp_hold", 32'(out_valid), 32'd1);
    chk("bp_cnt", 32'(corr_cnt), 32'd1);
    @(negedge clk);
    #1 chk("bp_idle", 32'(out_valid), 32'd0);
    chk("bp_next_grant", 32'(ch_ready), 32'b0010);
    @(negedge clk);
    ch_valid = '0;
    @(negedge clk);
    #1 chk("bp_ch1_out", 32'(out_ch), 32'd1);
    chk("bp_ch1_corr", 32'(out_corr), 32'd0);

    // Counter saturation at 4'hF with no wrap.
    do_reset();
    for (int n = 0; n < 17; n++) run_word(n % 4, 7'h4F, 4'hB, 3'd3, 1'b1);
    chk("sat_cnt", 32'(corr_cnt), 32'hF);

    // Asynchronous reset while a word sits in CALC.
    @(negedge clk);
    offer(2, 7'h6B);
    #1 chk("ar_grant", 32'(ch_ready), 32'b0100);
    @(negedge clk);
    ch_valid = '0;
    #2 rst_n = 1'b0;
    #1 chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_data", 32'(out_data), 32'd0);
    chk("ar_syn", 32'(out_syn), 32'd0);
    chk("ar_corr", 32'(out_corr), 32'd0);
    chk("ar_cnt", 32'(corr_cnt), 32'd0);
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("ar_no_stale", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    ch_code[2*7 +: 7] = 7'h4B;
    ch_code[3*7 +: 7] = 7'h7F;
    ch_valid = 4'b1100;
    #1 chk("ar_ptr0_grant", 32'(ch_ready), 32'b0100);
    @(negedge clk);
    ch_valid = 4'b1000;
    @(negedge clk);
    #1 chk("ar_out_ch2", 32'(out_ch), 32'd2);
    chk("ar_out_data2", 32'(out_data), 32'hB);
    @(negedge clk);
    #1 chk("ar_next_grant", 32'(ch_ready), 32'b1000);
    @(negedge clk);
    ch_valid = '0;
    @(negedge clk);
    #1 chk("ar_out_ch3", 32'(out_ch), 32'd3);
    chk("ar_out_data3", 32'(out_data), 32'hF);

    // clr_cnt coinciding with an increment wins.
    run_word(0, 7'h4F, 4'hB, 3'd3, 1'b1);
    run_word(1, 7'h4A, 4'hB, 3'd6, 1'b1);
    @(negedge clk);
    offer(3, 7'h49);
    @(negedge clk);
    ch_valid = '0;
    clr_cnt  = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    #1 chk("clr_cnt", 32'(corr_cnt), 32'd0);
    chk("clr_fsm", 32'(out_valid), 32'd1);
    chk("clr_corr", 32'(out_corr), 32'd1);
    @(negedge clk);
    #1 chk("clr_idle", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
